// File: rtl/demux1_5_buf.sv
// ---------------------------------------------------------------------------
// demux1_5_buf
//
// One-to-five demultiplexer with a one-entry register per output channel.
// An accepted input word is steered to the channel named by sel and held
// there, with a valid flag, until that channel's consumer takes it.
// Words sent to a non-existent channel (sel = 5..7) are accepted and
// discarded. A saturating counter records how many were discarded.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset
//   in_data    word to be routed (SZE bits)
//   in_valid   in_data and sel are valid this cycle
//   sel        destination channel, 0..4 valid, 5..7 discarded
//   in_ready   block accepts the word this cycle (combinational)
//   out0..4    registered channel data
//   outbar0..4 bitwise complement of out0..4
//   out_valid  bit i set: channel i holds an undelivered word
//   out_ready  bit i set: channel i consumer takes the word this cycle
//   drop_cnt   saturating count of words discarded for an invalid sel
// ---------------------------------------------------------------------------
module demux1_5_buf #(
    parameter int SZE = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [SZE-1:0] in_data,
    input  logic           in_valid,
    input  logic [2:0]     sel,
    output logic           in_ready,
    output logic [SZE-1:0] out0,
    output logic [SZE-1:0] out1,
    output logic [SZE-1:0] out2,
    output logic [SZE-1:0] out3,
    output logic [SZE-1:0] out4,
    output logic [SZE-1:0] outbar0,
    output logic [SZE-1:0] outbar1,
    output logic [SZE-1:0] outbar2,
    output logic [SZE-1:0] outbar3,
    output logic [SZE-1:0] outbar4,
    output logic [4:0]     out_valid,
    input  logic [4:0]     out_ready,
    output logic [7:0]     drop_cnt
);

    logic [SZE-1:0] data_q [5];
    logic [4:0]     valid_q;
    logic [7:0]     drop_q;

    logic           sel_ok;
    logic [4:0]     sel_hot;
    logic           accept;
    logic [4:0]     load;
    logic           drop;

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        sel_ok  = (sel <= 3'd4);
        sel_hot = 5'd0;
        for (int i = 0; i < 5; i++) begin
            if (sel == 3'(i)) begin
                sel_hot[i] = 1'b1;
            end
        end

        // Ready depends only on the selected channel's register state and
        // its consumer, never on in_valid. Invalid selects are always
        // accepted so they can be counted and discarded.
        in_ready = 1'b1;
        if (sel_ok) begin
            in_ready = |(sel_hot & (~valid_q | out_ready));
        end

        accept = in_valid & in_ready;
        load   = accept ? sel_hot : 5'd0;
        drop   = accept & ~sel_ok;
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // The data registers are cleared too: outputs must read zero
            // (and outbar all ones) straight after reset.
            for (int i = 0; i < 5; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= 5'd0;
            drop_q  <= 8'd0;
        end else begin
            // A drain clears the flag unless the same edge reloads it.
            // out_ready on an empty channel clears an already-clear bit.
            valid_q <= load | (valid_q & ~out_ready);

            // Data is only ever written on a load; a drain leaves it as is.
            for (int i = 0; i < 5; i++) begin
                if (load[i]) begin
                    data_q[i] <= in_data;
                end
            end

            if (drop && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign out0 = data_q[0];
    assign out1 = data_q[1];
    assign out2 = data_q[2];
    assign out3 = data_q[3];
    assign out4 = data_q[4];

    assign outbar0 = ~data_q[0];
    assign outbar1 = ~data_q[1];
    assign outbar2 = ~data_q[2];
    assign outbar3 = ~data_q[3];
    assign outbar4 = ~data_q[4];

    assign out_valid = valid_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_demux1_5_buf.sv
// ---------------------------------------------------------------------------
// tb_demux1_5_buf
//
// Self-checking bench for demux1_5_buf (SZE = 4). Directed scenarios for
// routing, stall, back-to-back loads, simultaneous drains, invalid selects
// with counter saturation and reset mid-operation, followed by a random
// phase. Expected values come from a channel-level reference model held
// in plain arrays.
// ---------------------------------------------------------------------------
module tb_demux1_5_buf;

    localparam int SZE = 4;

    logic           clk;
    logic           rst;
    logic [SZE-1:0] in_data;
    logic           in_valid;
    logic [2:0]     sel;
    logic           in_ready;
    logic [SZE-1:0] out0, out1, out2, out3, out4;
    logic [SZE-1:0] outbar0, outbar1, outbar2, outbar3, outbar4;
    logic [4:0]     out_valid;
    logic [4:0]     out_ready;
    logic [7:0]     drop_cnt;

    demux1_5_buf #(.SZE(SZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .sel       (sel),
        .in_ready  (in_ready),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out4      (out4),
        .outbar0   (outbar0),
        .outbar1   (outbar1),
        .outbar2   (outbar2),
        .outbar3   (outbar3),
        .outbar4   (outbar4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [SZE-1:0] obs_out [5];
    logic [SZE-1:0] obs_bar [5];
    assign obs_out[0] = out0;
    assign obs_out[1] = out1;
    assign obs_out[2] = out2;
    assign obs_out[3] = out3;
    assign obs_out[4] = out4;
    assign obs_bar[0] = outbar0;
    assign obs_bar[1] = outbar1;
    assign obs_bar[2] = outbar2;
    assign obs_bar[3] = outbar3;
    assign obs_bar[4] = outbar4;

    // Reference model: one slot per channel plus a drop tally.
    int m_data [5];
    bit m_full [5];
    int m_drops;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] model_valid();
        logic [4:0] v;
        for (int c = 0; c < 5; c++) v[c] = m_full[c];
        return v;
    endfunction

    task automatic check_state(input string tag);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("%s_out%0d", tag, c), {28'd0, obs_out[c]}, m_data[c]);
            check($sformatf("%s_outbar%0d", tag, c), {28'd0, obs_bar[c]}, (~m_data[c]) & 32'hF);
        end
        check($sformatf("%s_out_valid", tag), {27'd0, out_valid}, {27'd0, model_valid()});
        check($sformatf("%s_drop_cnt", tag), {24'd0, drop_cnt}, m_drops);
    endtask

    // One clock cycle: drive inputs, check ready before the edge, advance
    // the model on the edge, then check all outputs just after it.
    task automatic step(input bit r, input bit v, input int s, input int d,
                        input bit [4:0] ordy, input string tag);
        bit exp_rdy;
        bit acc;
        rst       = r;
        in_valid  = v;
        sel       = 3'(s);
        in_data   = 4'(d);
        out_ready = ordy;
        #1;
        exp_rdy = (s >= 5) ? 1'b1 : (!m_full[s] || ordy[s]);
        check($sformatf("%s_in_ready", tag), {31'd0, in_ready}, {31'd0, exp_rdy});
        @(posedge clk);
        if (r) begin
            for (int c = 0; c < 5; c++) begin
                m_data[c] = 0;
                m_full[c] = 1'b0;
            end
            m_drops = 0;
        end else begin
            acc = v && exp_rdy;
            for (int c = 0; c < 5; c++) begin
                if (m_full[c] && ordy[c]) m_full[c] = 1'b0;
            end
            if (acc && s < 5) begin
                m_data[s] = d & 'hF;
                m_full[s] = 1'b1;
            end
            if (acc && s >= 5 && m_drops < 255) m_drops++;
        end
        #1;
        check_state(tag);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        sel       = 3'd0;
        in_data   = '0;
        out_ready = 5'd0;
        for (int c = 0; c < 5; c++) begin
            m_data[c] = 0;
            m_full[c] = 1'b0;
        end
        m_drops = 0;

        // Reset state.
        step(1, 0, 0, 0, 5'b00000, "reset0");
        step(1, 0, 0, 0, 5'b00000, "reset1");
        check("reset_outbar0", {28'd0, outbar0}, 32'hF);
        check("reset_out_valid", {27'd0, out_valid}, 32'h0);

        // Routing and stall.
        step(0, 1, 2, 'hE, 5'b00000, "route");
        check("route_out2", {28'd0, out2}, 32'hE);
        check("route_outbar2", {28'd0, outbar2}, 32'h1);
        check("route_valid", {27'd0, out_valid}, 32'h04);
        step(0, 1, 2, 'h5, 5'b00000, "stall");
        check("stall_out2", {28'd0, out2}, 32'hE);

        // Back-to-back load while draining.
        step(0, 1, 2, 'h3, 5'b00100, "b2b");
        check("b2b_out2", {28'd0, out2}, 32'h3);
        check("b2b_valid2", {31'd0, out_valid[2]}, 32'h1);

        // Simultaneous drains of 0 and 4 with a load into 1.
        step(0, 0, 0, 0, 5'b00100, "drain2");
        step(0, 1, 0, 'hA, 5'b00000, "fill0");
        step(0, 1, 4, 'hB, 5'b00000, "fill4");
        step(0, 1, 1, 'h7, 5'b10001, "simul");
        check("simul_valid", {27'd0, out_valid}, 32'h02);
        check("simul_out1", {28'd0, out1}, 32'h7);
        check("simul_out0", {28'd0, out0}, 32'hA);
        check("simul_out4", {28'd0, out4}, 32'hB);
        // out_ready on empty channels has no effect; invalid in_valid ignored.
        step(0, 0, 3, 'h9, 5'b11101, "idle");

        // Invalid select and counter saturation.
        for (int i = 0; i < 3; i++) step(0, 1, 6, 'hC, 5'b00000, "drop");
        check("drop3_cnt", {24'd0, drop_cnt}, 32'd3);
        check("drop3_valid", {27'd0, out_valid}, 32'h02);
        for (int i = 0; i < 300; i++) step(0, 1, 5 + (i % 3), i, 5'b00000, "sat");
        check("sat_cnt", {24'd0, drop_cnt}, 32'd255);

        // Random phase.
        step(1, 0, 0, 0, 5'b00000, "rreset");
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) == 0), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 15),
                 5'($urandom_range(0, 31)), "rand");
        end

        // Reset mid-operation: all channels full, drop_cnt = 9.
        step(1, 0, 0, 0, 5'b00000, "mreset");
        for (int i = 0; i < 9; i++) step(0, 1, 7, 0, 5'b00000, "mdrop");
        for (int c = 0; c < 5; c++) step(0, 1, c, c + 5, 5'b00000, "mfill");
        check("mid_valid", {27'd0, out_valid}, 32'h1F);
        check("mid_drop", {24'd0, drop_cnt}, 32'd9);
        step(1, 1, 3, 'h6, 5'b01000, "midrst");
        check("midrst_out3", {28'd0, out3}, 32'h0);
        check("midrst_outbar3", {28'd0, outbar3}, 32'hF);
        check("midrst_valid", {27'd0, out_valid}, 32'h0);
        check("midrst_drop", {24'd0, drop_cnt}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux1_5_buf.md
DEMUX1_5_BUF -- requirements
Module: demux1_5_buf

Interface
REQ-001 SHALL have parameter: SZE, default 4, data width of the input and of each output channel.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port: in_data  input  SZE  word to be routed.
REQ-005 SHALL have port: in_valid  input  1  in_data and sel are valid this cycle.
REQ-006 SHALL have port: sel  input  3  destination channel; 0..4 are valid, 5..7 are invalid.
REQ-007 SHALL have port: in_ready  output  1  block accepts the word this cycle.
REQ-008 SHALL have ports: out0..out4  output  SZE each  registered channel data.
REQ-009 SHALL have ports: outbar0..outbar4  output  SZE each  bitwise complement of out0..out4.
REQ-010 SHALL have port: out_valid  output  5  bit i set means channel i holds an undelivered word.
REQ-011 SHALL have port: out_ready  input  5  bit i set means the channel i consumer takes the word this cycle.
REQ-012 SHALL have port: drop_cnt  output  8  count of words accepted with an invalid sel.

Function
REQ-013 SHALL hold each channel in a one-entry register: data register outN plus flag out_valid[N].
REQ-014 SHALL define an input transfer as in_valid & in_ready at a rising clk edge.
REQ-015 SHALL define a channel-N transfer as out_valid[N] & out_ready[N] at a rising clk edge.
REQ-016 SHALL drive in_ready combinationally:
- 1 when sel is 5..7;
- otherwise ~out_valid[sel] | out_ready[sel].
REQ-017 SHALL NOT make in_ready depend on in_valid.
REQ-018 SHALL, on an input transfer with sel = N (0..4), load in_data into outN and set out_valid[N] on that edge.
- The word is visible one cycle after acceptance (latency 1).
REQ-019 SHALL clear out_valid[N] on a channel-N transfer unless the same edge loads channel N.
- A same-edge load leaves out_valid[N] at 1 and outN holds the new word (back-to-back throughput 1 word/cycle per channel).
REQ-020 SHALL leave outN unchanged when channel N is not loaded; data SHALL NOT be zeroed on drain.
REQ-021 SHALL leave every channel other than sel unaffected by an input transfer.
REQ-022 SHALL keep channels independent: any number of channel transfers may occur on the same edge as one input transfer.
REQ-023 SHALL, on an input transfer with sel = 5..7:
- discard the word;
- leave all channels unchanged;
- increment drop_cnt, saturating at 255.
REQ-024 SHALL keep outN and outN data stable while out_valid[N] = 1 and out_ready[N] = 0.
REQ-025 SHALL ignore in_data and sel when in_valid = 0.
REQ-026 SHALL generate outbarN = ~outN combinationally from the register, with no extra latency.
REQ-027 SHALL give out_ready[N] no effect while out_valid[N] = 0.

Reset
REQ-028 SHALL, on any edge with rst = 1, clear out0..out4 to 0, out_valid to 5'b00000 and drop_cnt to 0; outbar0..outbar4 SHALL then read all ones.
REQ-029 SHALL give rst priority over any same-edge input or channel transfer; a word presented during reset is lost and not counted.
REQ-030 SHALL drive in_ready per REQ-016 during reset from the current register state; no transfer takes effect on a reset edge.

Verification
REQ-031 SHALL cover basic routing and stall (SZE=4):
- Stimulus: after reset, in_data=4'hE, sel=2, in_valid=1 for one cycle, out_ready=0.
- Response: next cycle out2=4'hE, outbar2=4'h1, out_valid=5'b00100.
- Then with sel=2, in_valid=1: in_ready=0.
REQ-032 SHALL cover back-to-back loading:
- Stimulus: channel 2 full; out_ready[2]=1, in_data=4'h3, sel=2, in_valid=1.
- Response: in_ready=1; next cycle out2=4'h3, out_valid[2]=1.
REQ-033 SHALL cover simultaneous events:
- Stimulus: channels 0 and 4 full; out_ready=5'b10001 with sel=1, in_data=4'h7.
- Response: next cycle out_valid=5'b00010, out1=4'h7; out0 and out4 keep their old data.
REQ-034 SHALL cover invalid select and saturation:
- Stimulus: sel=6, in_valid=1 for 3 cycles.
- Response: in_ready=1 throughout; drop_cnt=3; out_valid unchanged.
- Then drive 300 drops: drop_cnt=255.
REQ-035 SHALL cover reset mid-operation:
- Stimulus: out_valid=5'b11111 and drop_cnt=9; rst=1 on the same edge as an input transfer to channel 3.
- Response: next cycle all outN=0, outbarN=4'hF, out_valid=0, drop_cnt=0.
